dds_gain_ctrl: RTL and testbench
================================

Name: dds_gain_ctrl

Overview:
- Burst-envelope sequencer for the DDS output scaler.
- Generates the sample-rate `valid` strobe and the signed 16-bit gain word `data_m` that the scaler multiplies into each 8-bit DDS sample.
- Per burst: ramp gain up, hold for a programmed number of samples, ramp down to zero. This gives click-free TX bursts on the DAC path.
- Sits between the control/register logic and the DDS output scaler.

Parameters:
- GAIN_W, 16, width of the gain word (signed; only non-negative values are produced)
- LEN_W, 16, width of the hold-length counter
- DIV_W, 8, width of the strobe divider

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle burst request
- abort  in  1  single-cycle request to end the burst early through a ramp-down
- gain_target  in  GAIN_W  plateau gain; bit 15 is ignored (range 0..32767)
- ramp_step  in  GAIN_W  gain increment per strobe; bit 15 is ignored
- hold_len  in  LEN_W  plateau length in strobes
- rate_div  in  DIV_W  strobe period minus 1, in clk cycles
- valid  out  1  sample strobe to the scaler
- data_m  out  GAIN_W  gain word to the scaler
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at burst completion

Behaviour:
- Reset (async, rst_n=0): valid=0, data_m=0, busy=0, done=0, divider=0, state=IDLE. Release is sampled on the next clk edge.
- Strobe divider:
  - Free-runs whenever out of reset, independent of state.
  - Counts 0..rate_div; valid=1 for one cycle when count==rate_div, then the count returns to 0.
  - rate_div=0 → valid=1 every cycle.
  - A rate_div change takes effect at the next wrap.
- All gain updates happen only on clock edges where valid=1. The new data_m is visible from the following cycle, so the scaler sees each gain value for one full strobe period.
- Configuration latch: gain_target, ramp_step and hold_len are latched on the start-accept cycle. Later input changes have no effect until the next burst.
- Effective step = (ramp_step==0) ? 32767 : ramp_step. A zero step means an instant jump, never a lock-up.
- FSM states: IDLE, RAMP_UP, HOLD, RAMP_DOWN.
  - IDLE: data_m=0. If start=1 → latch config, go to RAMP_UP on the next cycle. start is accepted regardless of valid.
  - RAMP_UP: on each strobe, data_m = min(data_m + step, target), computed with 17-bit unsigned arithmetic and saturated.
    - When the updated value equals target → HOLD, hold counter cleared.
    - target=0 → the first strobe reaches HOLD with data_m=0.
  - HOLD: data_m is constant. On each strobe, hold_cnt increments; when hold_cnt reaches hold_len-1 on a strobe → RAMP_DOWN.
    - hold_len=0 → leave HOLD on the cycle after entry without waiting for a strobe.
  - RAMP_DOWN: on each strobe, data_m = max(data_m - step, 0), no wrap below 0.
    - When the updated value is 0 → IDLE, and done=1 for exactly one cycle (the cycle after that edge).
- abort:
  - In RAMP_UP or HOLD → RAMP_DOWN next cycle; data_m keeps its current value and ramps down from there.
  - In RAMP_DOWN or IDLE → ignored.
- start while busy=1 is ignored; it is neither queued nor relatched.
- start and abort in the same IDLE cycle → start wins; abort is ignored.
- Reset mid-burst → data_m drops to 0 immediately (async). No done pulse.
- data_m is always in the range 0..32767, so bit 15 is always 0.

Decomposition:
- Shared package dds_pkg:
  - GAIN_W
  - GAIN_MAX = 16'h7FFF
  - state enum codes: IDLE=2'd0, RAMP_UP=2'd1, HOLD=2'd2, RAMP_DOWN=2'd3
- One sub-module, dds_strobe_div: rate_div → valid. Reusable for other sample-rate strobes in the TX chain.
- The FSM, saturating add/subtract and hold counter stay in dds_gain_ctrl.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-simulation, then rate_div=3 → valid pulses every 4 clk; data_m=0, busy=0, done=0 throughout idle.
2. Nominal burst: target=1000, step=300, hold_len=4, rate_div=0 →
   - data_m sequence: 300, 600, 900, 1000 ×4 strobes, 700, 400, 100, 0
   - done pulses once, one cycle after 0 is reached; busy falls in the same cycle.
3. Zero step / zero hold: target=32767, step=0, hold_len=0 → 32767 on the first strobe, immediate RAMP_DOWN, 0 on the next strobe, then done.
4. Abort during hold: target=500, step=250, hold_len=100, abort after the 3rd hold strobe → data_m 250, 0, done; hold never completes.
5. Ignored requests: start pulsed while busy, and start changes to gain_target while in HOLD → plateau stays at the latched value; only one done pulse.
6. Async reset mid-ramp: rst_n=0 while data_m=600 → data_m=0 and busy=0 in the same cycle without waiting for clk. No done pulse. After release the FSM is in IDLE and the next start runs a clean burst.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS burst gain sequencer.
// Provides gain width, positive full scale and FSM state codes.
package dds_pkg;

  localparam int GAIN_W = 16;
  localparam logic [15:0] GAIN_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/dds_strobe_div.sv
// Free-running sample strobe divider: valid pulses once per rate_div+1 clks.
// Ports: clk, rst_n, rate_div (period-1, taken at each wrap), valid (pulse).
module dds_strobe_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] rate_div,
  output logic             valid
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // Period is sampled only at wrap so a mid-period change
  // can never strand the counter above its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
      valid <= 1'b0;
    end else if (cnt >= div_q) begin
      cnt   <= '0;
      div_q <= rate_div;
      valid <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_gain_ctrl.sv
// Burst envelope sequencer: ramp up, hold, ramp down of the DDS gain word.
// Ports: clk, rst_n, start, abort, gain_target, ramp_step, hold_len,
//        rate_div, valid, data_m, busy, done.
module dds_gain_ctrl #(
  parameter int GAIN_W = 16,
  parameter int LEN_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic [GAIN_W-1:0] ramp_step,
  input  logic [LEN_W-1:0]  hold_len,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              valid,
  output logic [GAIN_W-1:0] data_m,
  output logic              busy,
  output logic              done
);

  import dds_pkg::*;

  localparam logic [GAIN_W-1:0] GMAX = GAIN_W'(GAIN_MAX);

  state_t state, state_n;

  logic [GAIN_W-1:0] gain_q, gain_n;
  logic [GAIN_W-1:0] tgt_q, tgt_n;
  logic [GAIN_W-1:0] stp_q, stp_n;
  logic [LEN_W-1:0]  hlen_q, hlen_n;
  logic [LEN_W-1:0]  hcnt_q, hcnt_n;
  logic              done_n;

  logic [GAIN_W-1:0] tgt_in;
  logic [GAIN_W-1:0] stp_in;
  logic [GAIN_W:0]   sum;
  logic [GAIN_W-1:0] up_val;
  logic [GAIN_W-1:0] dn_val;
  logic [LEN_W:0]    cnt_inc;
  logic [LEN_W:0]    len_m1;

  dds_strobe_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .rate_div (rate_div),
    .valid    (valid)
  );

  // Sign bit of the config words is dropped; zero step means jump.
  assign tgt_in = gain_target & GMAX;
  assign stp_in = ((ramp_step & GMAX) == '0)
                ? GMAX : (ramp_step & GMAX);

  assign sum    = {1'b0, gain_q} + {1'b0, stp_q};
  assign up_val = (sum >= {1'b0, tgt_q})
                ? tgt_q : sum[GAIN_W-1:0];
  assign dn_val = (gain_q > stp_q)
                ? (gain_q - stp_q) : '0;

  assign cnt_inc = {1'b0, hcnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign len_m1  = {1'b0, hlen_q} - {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    state_n = state;
    gain_n  = gain_q;
    tgt_n   = tgt_q;
    stp_n   = stp_q;
    hlen_n  = hlen_q;
    hcnt_n  = hcnt_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        gain_n = '0;
        if (start) begin
          tgt_n   = tgt_in;
          stp_n   = stp_in;
          hlen_n  = hold_len;
          state_n = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (abort) begin
          state_n = RAMP_DOWN;
        end else if (valid) begin
          gain_n = up_val;
          if (up_val == tgt_q) begin
            state_n = HOLD;
            hcnt_n  = '0;
          end
        end
      end
      HOLD: begin
        // The entry strobe already counts as the first plateau period.
        if (abort || hlen_q == '0) begin
          state_n = RAMP_DOWN;
        end else if (valid) begin
          hcnt_n = cnt_inc[LEN_W-1:0];
          if (cnt_inc >= len_m1) begin
            state_n = RAMP_DOWN;
          end
        end
      end
      RAMP_DOWN: begin
        if (valid) begin
          gain_n = dn_val;
          if (dn_val == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gain_q <= '0;
      tgt_q  <= '0;
      stp_q  <= '0;
      hlen_q <= '0;
      hcnt_q <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      gain_q <= gain_n;
      tgt_q  <= tgt_n;
      stp_q  <= stp_n;
      hlen_q <= hlen_n;
      hcnt_q <= hcnt_n;
      done   <= done_n;
    end
  end

  assign data_m = gain_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dds_gain_ctrl.sv
// Scoreboard bench for dds_gain_ctrl.
// Gain per strobe and done events are queued at stimulus, popped at output.
module tb_dds_gain_ctrl;

  localparam int DONE_EV = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gain_target = '0;
  logic [15:0] ramp_step = '0;
  logic [15:0] hold_len = '0;
  logic [7:0]  rate_div = '0;
  logic        valid;
  logic [15:0] data_m;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  dds_gain_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .gain_target (gain_target),
    .ramp_step   (ramp_step),
    .hold_len    (hold_len),
    .rate_div    (rate_div),
    .valid       (valid),
    .data_m      (data_m),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_pop(string tag, int ev);
    if (exp_q.size() == 0)
      check({tag, "_extra"}, ev, -1);
    else
      check(tag, ev, exp_q.pop_front());
  endtask

  // Gain presented on each strobe while busy, plus done events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && busy && data_m != 16'd0)
        sb_pop("gain", int'(data_m));
      if (done) begin
        sb_pop("done", DONE_EV + int'(data_m));
        check("done_busy", int'(busy), 0);
      end
    end
  end

  task automatic push(int v, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic start_burst(int t, int s, int h);
    @(posedge clk);
    #1;
    gain_target = 16'(t);
    ramp_step   = 16'(s);
    hold_len    = 16'(h);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_timeout"}, int'(k < 300), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_busy"}, int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int gaps;
    int npulse;
    int k;

    // 1: async reset mid-simulation, idle strobe at rate_div=3
    #12;
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data_m), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rate_div = 8'd3;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    last = -1;
    gaps = 0;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_out", int'({data_m != 16'd0, busy, done}), 0);
      if (valid) begin
        npulse++;
        if (last >= 0) begin
          check("strobe_gap", c - last, 4);
          gaps++;
        end
        last = c;
      end
    end
    check("strobe_cnt", npulse, 5);
    rate_div = 8'd0;
    repeat (8) @(posedge clk);

    // 2: nominal burst
    push(300, 1); push(600, 1); push(900, 1);
    push(1000, 4);
    push(700, 1); push(400, 1); push(100, 1);
    push(DONE_EV, 1);
    start_burst(1000, 300, 4);
    wait_idle("nominal");

    // 3: zero step, zero hold
    push(32767, 2);
    push(DONE_EV, 1);
    start_burst(32767, 0, 0);
    wait_idle("zero");

    // 4: abort on the plateau
    push(250, 1);
    push(500, 5);
    push(250, 1);
    push(DONE_EV, 1);
    start_burst(500, 250, 100);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle("abort");

    // 5: start while busy is ignored, config stays latched
    push(500, 1);
    push(1000, 4);
    push(500, 1);
    push(DONE_EV, 1);
    start_burst(1000, 500, 4);
    repeat (2) @(posedge clk);
    #1;
    gain_target = 16'd2000;
    ramp_step   = 16'd7;
    hold_len    = 16'd1;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ignored");
    repeat (10) @(posedge clk);
    #1;
    check("ignored_noq", int'(busy), 0);

    // 6: async reset mid-ramp, then a clean burst
    push(300, 1); push(600, 1);
    start_burst(1000, 300, 4);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (data_m == 16'd600) break;
    end
    check("ramp_reach", int'(k < 50), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", int'(data_m), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_q", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("arst_hold", int'({data_m != 16'd0, busy, done}), 0);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", int'(busy), 0);
    push(300, 1); push(600, 1); push(900, 1);
    push(1000, 4);
    push(700, 1); push(400, 1); push(100, 1);
    push(DONE_EV, 1);
    start_burst(1000, 300, 4);
    wait_idle("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
